// File: rtl/counter_reload_seq.sv
// counter_reload_seq: walks a small reload table, driving the down-counter's
// shared load bus and setup code on each rising edge of the counter's match flag.
// Counts completed passes through entries 0..len and can stop after `loops` passes.
// Optional feature macro: BYTE_LOAD_EN adds a per-entry low-byte-load flag
// (written through port wr_byte); flagged entries load with setup=10 and drive
// only data[7:0] on the bus.
module counter_reload_seq #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             match,
  inout  tri   [WIDTH-1:0] counter_value,
  output logic [1:0]       setup,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
`ifdef BYTE_LOAD_EN
  input  logic             wr_byte,
`endif
  input  logic [IDX_W-1:0] len,
  input  logic [7:0]       loops,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx,
  output logic [7:0]       pass_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [WIDTH-1:0] load_q;
  logic             match_q;
  logic             rise;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W-1:0] ld_idx;
  logic [WIDTH-1:0] ld_data;
  logic [1:0]       ld_code;
  logic [7:0]       pass_inc;
  logic             last_pass;

`ifdef BYTE_LOAD_EN
  logic [DEPTH-1:0] tbl_byte;
`endif

  assign rise = match & ~match_q;

  // Bus is only driven while a load code is presented to the counter.
  assign counter_value = (setup != 2'b00) ? load_q : {WIDTH{1'bz}};

  // Reload table: not reset, writable in any state. The capture below reads
  // the pre-edge contents, so a same-edge write is not seen by that load.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl[wr_addr] <= wr_data;
`ifdef BYTE_LOAD_EN
      tbl_byte[wr_addr] <= wr_byte;
`endif
    end
  end

  // Next entry to load and its bus word / setup code.
  always_comb begin
    nxt_idx   = (idx < len) ? idx + IDX_W'(1) : '0;
    ld_idx    = start ? '0 : nxt_idx;
    ld_data   = tbl[ld_idx];
    ld_code   = 2'b11;
`ifdef BYTE_LOAD_EN
    if (tbl_byte[ld_idx]) begin
      ld_data = {{(WIDTH-8){1'b0}}, tbl[ld_idx][7:0]};
      ld_code = 2'b10;
    end
`endif
    pass_inc  = (pass_cnt == 8'hFF) ? 8'hFF : pass_cnt + 8'd1;
    last_pass = (loops != 8'd0) && (pass_inc == loops);
  end

  // Sequencer FSM with registered outputs; stop beats start beats rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      setup    <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      pass_cnt <= 8'd0;
      match_q  <= 1'b0;
      load_q   <= '0;
    end else begin
      match_q <= match;
      if (stop) begin
        state <= IDLE;
        setup <= 2'b00;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        state    <= LOAD;
        setup    <= ld_code;
        load_q   <= ld_data;
        busy     <= 1'b1;
        done     <= 1'b0;
        idx      <= '0;
        pass_cnt <= 8'd0;
      end else begin
        case (state)
          LOAD: begin
            state <= WAIT;
            setup <= 2'b00;
          end
          WAIT: begin
            if (rise) begin
              idx <= nxt_idx;
              if (idx >= len) pass_cnt <= pass_inc;
              if (idx >= len && last_pass) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state  <= LOAD;
                setup  <= ld_code;
                load_q <= ld_data;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_reload_seq.sv
// Directed bench for counter_reload_seq: table walk, pass counting, held match,
// stop/start priority, table writes while busy, len=0 and pass saturation.
module tb_counter_reload_seq;

  logic        clk = 1'b0;
  logic        rst, match, wr_en, start, stop;
  logic [1:0]  wr_addr, len, idx;
  logic [15:0] wr_data;
  logic [7:0]  loops, pass_cnt;
  logic [1:0]  setup;
  logic        busy, done;
  wire  [15:0] bus;
`ifdef BYTE_LOAD_EN
  logic        wr_byte = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int nloads;
  logic [15:0] exp_seq [7] = '{16'd15, 16'd7, 16'd10, 16'd9, 16'd15, 16'd7, 16'd10};
  logic [15:0] init_tbl [4] = '{16'd9, 16'd15, 16'd7, 16'd10};

  always #5 clk = ~clk;

  counter_reload_seq #(.WIDTH(16), .DEPTH(4), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .match(match), .counter_value(bus), .setup(setup),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef BYTE_LOAD_EN
    .wr_byte(wr_byte),
`endif
    .len(len), .loops(loops), .start(start), .stop(stop),
    .busy(busy), .done(done), .idx(idx), .pass_cnt(pass_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One match pulse: rise sampled at first edge, low again at second.
  task automatic pulse_match();
    match = 1'b1; tick();
  endtask

  initial begin
    rst = 1'b1; match = 1'b0; wr_en = 1'b0; start = 1'b0; stop = 1'b0;
    wr_addr = '0; wr_data = '0; len = 2'd3; loops = 8'd2;
    tick(); tick();
    rst = 1'b0;
    chk("rst_setup", setup, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", idx, 0);
    chk("rst_pass", pass_cnt, 0);

    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = init_tbl[i]; tick();
    end
    wr_en = 1'b0;

    // Full table walk, two passes.
    start = 1'b1; tick(); start = 1'b0;
    chk("start_setup", setup, 2'b11);
    chk("start_bus", bus, 16'd9);
    chk("start_busy", busy, 1);
    tick();
    chk("wait_setup", setup, 2'b00);
    for (int i = 0; i < 7; i++) begin
      pulse_match();
      chk("walk_setup", setup, 2'b11);
      chk("walk_bus", bus, exp_seq[i]);
      chk("walk_idx", idx, 32'((i + 1) % 4));
      match = 1'b0; tick();
      chk("walk_wait", setup, 2'b00);
    end
    chk("pass_mid", pass_cnt, 1);
    pulse_match();
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_setup", setup, 2'b00);
    chk("end_pass", pass_cnt, 2);
    chk("end_idx", idx, 0);
    match = 1'b0; tick();
    chk("done_held", done, 1);

    // Held match gives exactly one reload.
    loops = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_pass", pass_cnt, 0);
    tick();
    nloads = 0;
    match = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (setup != 2'b00) nloads++;
    end
    chk("held_loads", nloads, 1);
    chk("held_idx", idx, 1);
    match = 1'b0; tick();

    // Rise during LOAD ignored; level already high in WAIT does not retrigger.
    start = 1'b1; tick(); start = 1'b0;
    match = 1'b1; tick();
    chk("loadrise_setup", setup, 2'b00);
    tick();
    chk("loadrise_setup2", setup, 2'b00);
    chk("loadrise_idx", idx, 0);
    match = 1'b0; tick();

    // stop with a simultaneous rise: IDLE, no load, idx held.
    pulse_match(); match = 1'b0; tick();
    chk("pre_stop_idx", idx, 1);
    match = 1'b1; stop = 1'b1; tick(); stop = 1'b0; match = 1'b0;
    chk("stop_setup", setup, 2'b00);
    chk("stop_busy", busy, 0);
    chk("stop_idx", idx, 1);
    tick();
    chk("idle_setup", setup, 2'b00);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_bus", bus, 16'd9);
    chk("restart_idx", idx, 0);
    tick();

    // Write while busy in WAIT on entry 0; next load uses new data.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h00AA; tick(); wr_en = 1'b0;
    pulse_match();
    chk("wr_busy_bus", bus, 16'h00AA);
    match = 1'b0; tick();
    // Same-edge write to the entry being captured: old data driven.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h0055; match = 1'b1; tick();
    wr_en = 1'b0;
    chk("same_edge_bus", bus, 16'd7);
    match = 1'b0; tick();
    pulse_match(); match = 1'b0; tick();
    pulse_match();
    chk("new_entry0_bus", bus, 16'd9);
    match = 1'b0; tick();
    pulse_match();
    chk("new_entry1_bus", bus, 16'h00AA);
    match = 1'b0; tick();
    pulse_match();
    chk("written_bus", bus, 16'h0055);
    match = 1'b0; tick();

    // len=0: every match reloads entry 0 and counts a pass; saturates at FF.
    len = 2'd0;
    start = 1'b1; tick(); start = 1'b0; tick();
    pulse_match();
    chk("len0_bus", bus, 16'd9);
    chk("len0_pass", pass_cnt, 1);
    chk("len0_idx", idx, 0);
    match = 1'b0; tick();
    for (int i = 0; i < 258; i++) begin
      pulse_match(); match = 1'b0; tick();
    end
    chk("sat_pass", pass_cnt, 8'hFF);
    chk("sat_busy", busy, 1);

`ifdef BYTE_LOAD_EN
    len = 2'd3;
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 16'h127F; wr_byte = 1'b1; tick();
    wr_en = 1'b0; wr_byte = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    pulse_match(); match = 1'b0; tick();
    pulse_match();
    chk("byte_setup", setup, 2'b10);
    chk("byte_bus", bus, 16'h007F);
    match = 1'b0; tick();
`endif

    stop = 1'b1; tick(); stop = 1'b0;
    chk("final_stop_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
